// File: rtl/jt12_host_pkg.sv
// Shared definitions for the JT12 host write sequencer: FSM state encoding,
// chip address constants and the request entry layout.
package jt12_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_GAP  = 3'd2,
      ST_DATA = 3'd3,
      ST_HOLD = 3'd4,
      ST_WAIT = 3'd5
   } state_t;

   // Low bit of ym_addr: 0 latches a register number, 1 writes its value.
   localparam logic ADDR_SEL  = 1'b0;
   localparam logic ADDR_DATA = 1'b1;

   // One buffered register write, 17 bits: {part, reg, data}.
   typedef struct packed {
      logic       part;
      logic [7:0] rg;
      logic [7:0] data;
   } req_t;

   // Key used by the register-address cache: bank plus register number.
   function automatic logic [8:0] req_key(input req_t r);
      return {r.part, r.rg};
   endfunction

endpackage

// File: rtl/jt12_host_fifo.sv
// Request buffer for the JT12 host writer: synchronous FIFO with show-ahead
// read data and an occupancy count. A write while full is taken only when a
// read happens in the same cycle.
module jt12_host_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_ok;
   logic          rd_ok;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign rd_ok   = rd_en & ~empty;
   assign wr_ok   = wr_en & (~full | rd_ok);
   assign rd_data = mem[rd_ptr];

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Storage array; no reset needed, contents are qualified by level.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy; simultaneous push and pop leave level unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_ok, rd_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/jt12_host_wr.sv
// JT12 host write sequencer. Buffers register write requests and plays them
// onto the chip bus as address/data strobe pairs, skipping the address strobe
// when the chip already points at the same register, then waits for busy.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | bus quiet; pops the next request when the buffer is non-empty
// ADDR  | address strobe on the bus ({part,0}, reg); cache updated
// GAP   | strobe low, address/data bus held
// DATA  | data strobe on the bus ({part,1}, data)
// HOLD  | strobe low, one cycle for the chip to raise busy
// WAIT  | waiting for busy low, bounded by BUSY_TO cycles
module jt12_host_wr
   import jt12_host_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BUSY_TO    = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_part,
   input  logic [7:0]                   req_reg,
   input  logic [7:0]                   req_data,
   output logic [7:0]                   ym_din,
   output logic [1:0]                   ym_addr,
   output logic                         ym_write,
   input  logic                         ym_busy,
   output logic                         idle,
   output logic [$clog2(FIFO_DEPTH):0]  level,
   output logic                         err,
   input  logic                         err_clr
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = $clog2(BUSY_TO + 1);

   state_t         state;
   state_t         state_nx;
   req_t           head;
   req_t           cur;
   logic           fifo_empty;
   logic           fifo_full;
   logic           push;
   logic           pop;
   logic           cache_vld;
   logic [8:0]     cache_key;
   logic           cache_load;
   logic [CW-1:0]  wait_cnt;
   logic           timeout;
   logic           write_nx;
   logic [1:0]     addr_nx;
   logic [7:0]     din_nx;

   assign req_ready = (level < LW'(FIFO_DEPTH));
   assign push      = req_valid & req_ready;
   assign idle      = fifo_empty & (state == ST_IDLE);

   jt12_host_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (17)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data ({req_part, req_reg, req_data}),
      .rd_en   (pop),
      .rd_data (head),
      .level   (level),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Next state and next bus values; bus outputs are registered so each
   // transition decides what the chip sees during the following cycle.
   always_comb begin
      state_nx   = state;
      pop        = 1'b0;
      write_nx   = 1'b0;
      addr_nx    = ym_addr;
      din_nx     = ym_din;
      cache_load = 1'b0;
      timeout    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               write_nx = 1'b1;
               if (cache_vld && (req_key(head) == cache_key)) begin
                  state_nx = ST_DATA;
                  addr_nx  = {head.part, ADDR_DATA};
                  din_nx   = head.data;
               end else begin
                  state_nx = ST_ADDR;
                  addr_nx  = {head.part, ADDR_SEL};
                  din_nx   = head.rg;
               end
            end
         end
         ST_ADDR: begin
            state_nx   = ST_GAP;
            cache_load = 1'b1;
         end
         ST_GAP: begin
            state_nx = ST_DATA;
            write_nx = 1'b1;
            addr_nx  = {cur.part, ADDR_DATA};
            din_nx   = cur.data;
         end
         ST_DATA: state_nx = ST_HOLD;
         ST_HOLD: state_nx = ST_WAIT;
         ST_WAIT: begin
            if (!ym_busy) begin
               state_nx = ST_IDLE;
            end else if (wait_cnt == CW'(1)) begin
               timeout  = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State and registered chip bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ym_write <= 1'b0;
         ym_addr  <= '0;
         ym_din   <= '0;
      end else begin
         state    <= state_nx;
         ym_write <= write_nx;
         ym_addr  <= addr_nx;
         ym_din   <= din_nx;
      end
   end

   // In-flight request captured at pop; kept until the next pop.
   always_ff @(posedge clk) begin
      if (rst)      cur <= '0;
      else if (pop) cur <= head;
   end

   // Register-address cache: what the chip's address latch currently holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_vld <= 1'b0;
         cache_key <= '0;
      end else if (cache_load) begin
         cache_vld <= 1'b1;
         cache_key <= req_key(cur);
      end
   end

   // Busy-wait down-counter: loaded on the way into WAIT, timeout at one.
   always_ff @(posedge clk) begin
      if (rst)                                             wait_cnt <= '0;
      else if (state == ST_HOLD)                           wait_cnt <= CW'(BUSY_TO);
      else if (state == ST_WAIT && state_nx == ST_WAIT)    wait_cnt <= wait_cnt - CW'(1);
      else                                                 wait_cnt <= '0;
   end

   // Sticky timeout flag; a timeout in the same cycle wins over err_clr.
   always_ff @(posedge clk) begin
      if (rst)          err <= 1'b0;
      else if (timeout) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
   end

endmodule

// File: tb/tb_jt12_host_wr.sv
// Bench for jt12_host_wr: a chip-side monitor checks every strobe against an
// expected write list built from the request stream and an address-cache model.
module tb_jt12_host_wr;

   localparam int FIFO_DEPTH = 4;
   localparam int BUSY_TO    = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_part = 1'b0;
   logic [7:0] req_reg = '0;
   logic [7:0] req_data = '0;
   logic [7:0] ym_din;
   logic [1:0] ym_addr;
   logic       ym_write;
   logic       ym_busy = 1'b0;
   logic       idle;
   logic [2:0] level;
   logic       err;
   logic       err_clr = 1'b0;

   always #5 clk = ~clk;

   jt12_host_wr #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .BUSY_TO    (BUSY_TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_part  (req_part),
      .req_reg   (req_reg),
      .req_data  (req_data),
      .ym_din    (ym_din),
      .ym_addr   (ym_addr),
      .ym_write  (ym_write),
      .ym_busy   (ym_busy),
      .idle      (idle),
      .level     (level),
      .err       (err),
      .err_clr   (err_clr)
   );

   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic [9:0] exp_q[$];
   logic       m_cache_vld = 1'b0;
   logic [8:0] m_cache_key = '0;
   logic       busy_force = 1'b0;
   int         busy_cnt = 0;
   logic       prev_write = 1'b0;
   logic       last_sel = 1'b0;
   int         last_sel_cyc = 0;
   int         last_data_cyc = 0;
   int         strobe_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Chip view of a register write: the address strobe is skipped only when
   // the chip's address latch already holds the same bank/register.
   task automatic model_push(input logic p, input logic [7:0] r, input logic [7:0] d);
      if (!(m_cache_vld && m_cache_key == {p, r}))
         exp_q.push_back({p, 1'b0, r});
      exp_q.push_back({p, 1'b1, d});
      m_cache_vld = 1'b1;
      m_cache_key = {p, r};
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor and simple chip busy model.
   always @(negedge clk) begin
      logic [9:0] e;
      if (ym_write) begin
         strobe_cnt++;
         check_eq("write_pulse", prev_write, 1'b0);
         check_eq("strobe_has_exp", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("strobe", {ym_addr, ym_din}, e);
         end
         if (ym_addr[0]) begin
            if (last_sel) check_eq("gap", cyc - last_sel_cyc, 2);
            last_data_cyc = cyc;
            last_sel      = 1'b0;
         end else begin
            last_sel     = 1'b1;
            last_sel_cyc = cyc;
         end
      end
      prev_write = ym_write;
      if (ym_write && ym_addr[0]) busy_cnt = $urandom_range(1, 6);
      else if (busy_cnt > 0)      busy_cnt--;
      ym_busy = busy_force | (busy_cnt != 0);
   end

   task automatic send(input logic p, input logic [7:0] r, input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_part  = p;
      req_reg   = r;
      req_data  = d;
      while (!req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq("send_ready", req_ready, 1'b1);
      if (req_ready) begin
         @(posedge clk);
         model_push(p, r, d);
         #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(idle && !ym_busy) && n < 2000);
      check_eq("idle_reached", idle, 1'b1);
   endtask

   logic [7:0] regs [4] = '{8'h28, 8'hA4, 8'h30, 8'hB0};

   initial begin
      int s0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_idle", idle, 1'b1);
      check_eq("rst_level", level, 0);
      check_eq("rst_ready", req_ready, 1'b1);
      check_eq("rst_write", ym_write, 1'b0);
      check_eq("rst_addr", ym_addr, 0);
      check_eq("rst_din", ym_din, 0);
      check_eq("rst_err", err, 1'b0);

      // single request, first-strobe latency
      s0 = strobe_cnt;
      send(1'b0, 8'h28, 8'hF0);
      @(negedge clk);
      check_eq("lat_n", ym_write, 1'b0);
      @(negedge clk);
      check_eq("lat_n1", ym_write, 1'b1);
      wait_idle();
      check_eq("t1_strobes", strobe_cnt - s0, 2);
      check_eq("t1_drained", exp_q.size(), 0);

      // address cache hit
      send(1'b1, 8'hA4, 8'h22);
      wait_idle();
      s0 = strobe_cnt;
      send(1'b1, 8'hA4, 8'h33);
      wait_idle();
      check_eq("hit_strobes", strobe_cnt - s0, 1);
      check_eq("hit_drained", exp_q.size(), 0);

      // full buffer during a busy stall
      busy_force = 1'b1;
      for (int i = 0; i < 5; i++) send(1'b0, 8'h40 + 8'(i), 8'(i * 3 + 1));
      @(negedge clk);
      check_eq("full_ready", req_ready, 1'b0);
      check_eq("full_level", level, 4);
      check_eq("full_idle", idle, 1'b0);
      busy_force = 1'b0;
      wait_idle();
      check_eq("full_drained", exp_q.size(), 0);
      check_eq("full_level_end", level, 0);

      // busy timeout
      check_eq("err_pre", err, 1'b0);
      busy_force = 1'b1;
      send(1'b0, 8'h28, 8'hF0);
      s0 = 0;
      while (!err && s0 < 600) begin
         @(negedge clk);
         s0++;
      end
      check_eq("to_seen", err, 1'b1);
      check_eq("to_cycles", cyc - last_data_cyc, BUSY_TO + 2);
      busy_force = 1'b0;
      send(1'b1, 8'h31, 8'h55);
      wait_idle();
      check_eq("to_next_drained", exp_q.size(), 0);
      check_eq("err_sticky", err, 1'b1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_eq("err_clr", err, 1'b0);

      // reset while in GAP with two entries buffered
      busy_force = 1'b1;
      send(1'b0, 8'h10, 8'h11);
      send(1'b0, 8'h12, 8'h13);
      send(1'b0, 8'h14, 8'h15);
      check_eq("lvl_pre_rst", level, 2);
      rst = 1'b1;
      exp_q.delete();
      m_cache_vld = 1'b0;
      last_sel    = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      busy_force = 1'b0;
      @(negedge clk);
      check_eq("mrst_level", level, 0);
      check_eq("mrst_idle", idle, 1'b1);
      check_eq("mrst_write", ym_write, 1'b0);
      repeat (6) @(negedge clk);
      s0 = strobe_cnt;
      send(1'b0, 8'h10, 8'h16);
      wait_idle();
      check_eq("mrst_strobes", strobe_cnt - s0, 2);
      check_eq("mrst_drained", exp_q.size(), 0);

      // random traffic
      for (int i = 0; i < 80; i++) begin
         send(1'($urandom_range(0, 1)), regs[$urandom_range(0, 3)], 8'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      check_eq("rnd_drained", exp_q.size(), 0);
      check_eq("rnd_err", err, 1'b0);
      check_eq("rnd_level", level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
